// File: rtl/exe_pkg.sv
// Shared types and helpers for the EXE-stage writeback arbiter.
// wb_entry_t is the packed layout {data, rob_idx, rd} held in each skid slot;
// rob_age() measures distance from the ROB head, modulo 2**rob_w.
package exe_pkg;

  localparam int NUM_FU_D = 8;
  localparam int XLEN_D   = 32;
  localparam int ROB_W_D  = 3;
  localparam int RD_W_D   = 7;

  typedef struct packed {
    logic [XLEN_D-1:0]  data;
    logic [ROB_W_D-1:0] rob_idx;
    logic [RD_W_D-1:0]  rd;
  } wb_entry_t;

  // Age of a ROB index relative to the head; larger means younger.
  function automatic int unsigned rob_age(input int unsigned idx,
                                          input int unsigned head,
                                          input int unsigned rob_w);
    int unsigned mask;
    mask = (32'd1 << rob_w) - 32'd1;
    return (idx - head) & mask;
  endfunction

endpackage

// File: rtl/wb_skid_slot.sv
// One-entry skid slot for a functional-unit result channel.
// Holds an entry that lost arbitration; the channel is ready only while empty.
// Clear (granted) and kill (flushed) both empty the slot and win over capture.
module wb_skid_slot
  import exe_pkg::*;
#(
  parameter int W = $bits(wb_entry_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic         clear,
  input  logic         kill,
  input  logic [W-1:0] entry_in,
  output logic [W-1:0] entry,
  output logic         valid,
  output logic         ready
);

  // Slot occupancy and payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (clear || kill) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      entry <= entry_in;
    end
  end

  assign ready = !valid;

endmodule

// File: rtl/exe_wb_arbiter.sv
// EXE-stage result collection and writeback arbiter.
// Each FU channel offers either its buffered slot entry or its live input;
// up to NUM_WB candidates are granted per cycle onto the forwarding ports,
// which are registered one cycle later onto the wb ports. Candidates younger
// than a mispredicting instruction are dropped in the flush cycle.
// Optional feature: define WB_RR_ARB_EN for round-robin grant order;
// otherwise channel 0 has fixed highest priority.
// Handshake: a channel may assert fu_valid only while fu_ready is high; a
// presented result is always consumed that cycle (granted, captured or killed).
module exe_wb_arbiter
  import exe_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_D,
  parameter int NUM_WB = 1,
  parameter int XLEN   = XLEN_D,
  parameter int ROB_W  = ROB_W_D,
  parameter int RD_W   = RD_W_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FU-1:0]       fu_valid,
  input  logic [NUM_FU*XLEN-1:0]  fu_data,
  input  logic [NUM_FU*ROB_W-1:0] fu_rob_idx,
  input  logic [NUM_FU*RD_W-1:0]  fu_rd,
  output logic [NUM_FU-1:0]       fu_ready,
  input  logic                    flush,
  input  logic [ROB_W-1:0]        flush_rob_idx,
  input  logic [ROB_W-1:0]        rob_head,
  output logic [NUM_WB-1:0]       fwd_valid,
  output logic [NUM_WB*XLEN-1:0]  fwd_data,
  output logic [NUM_WB*ROB_W-1:0] fwd_rob_idx,
  output logic [NUM_WB*RD_W-1:0]  fwd_rd,
  output logic [NUM_WB-1:0]       wb_valid,
  output logic [NUM_WB*XLEN-1:0]  wb_data,
  output logic [NUM_WB*ROB_W-1:0] wb_rob_idx,
  output logic [NUM_WB*RD_W-1:0]  wb_rd
);

  localparam int EW    = XLEN + ROB_W + RD_W;
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [EW-1:0]     in_entry   [NUM_FU];
  logic [EW-1:0]     slot_entry [NUM_FU];
  logic [EW-1:0]     cand_entry [NUM_FU];
  logic [NUM_FU-1:0] slot_valid;
  logic [NUM_FU-1:0] cand_valid;
  logic [NUM_FU-1:0] cand_kill;
  logic [NUM_FU-1:0] eligible;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] capture;
  logic [NUM_FU-1:0] slot_clear;
  logic [NUM_FU-1:0] slot_kill;
  logic [NUM_WB-1:0] port_valid;
  logic [IDX_W-1:0]  port_sel [NUM_WB];
  logic [IDX_W-1:0]  start_idx;
  int unsigned       flush_age;

  // The flushing instruction itself survives; only strictly younger ones die.
  assign flush_age = rob_age(32'(flush_rob_idx), 32'(rob_head), ROB_W);

  for (genvar i = 0; i < NUM_FU; i++) begin : g_ch
    assign in_entry[i]   = {fu_data[i*XLEN +: XLEN], fu_rob_idx[i*ROB_W +: ROB_W],
                            fu_rd[i*RD_W +: RD_W]};
    assign cand_valid[i] = slot_valid[i] | fu_valid[i];
    assign cand_entry[i] = slot_valid[i] ? slot_entry[i] : in_entry[i];
    assign cand_kill[i]  = flush &&
                           (rob_age(32'(cand_entry[i][RD_W +: ROB_W]), 32'(rob_head), ROB_W)
                            > flush_age);
    assign eligible[i]   = cand_valid[i] & ~cand_kill[i];
    assign capture[i]    = fu_valid[i] & ~slot_valid[i] & ~grant[i] & ~cand_kill[i];
    assign slot_clear[i] = slot_valid[i] & grant[i];
    assign slot_kill[i]  = slot_valid[i] & cand_kill[i];

    wb_skid_slot #(.W(EW)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .capture  (capture[i]),
      .clear    (slot_clear[i]),
      .kill     (slot_kill[i]),
      .entry_in (in_entry[i]),
      .entry    (slot_entry[i]),
      .valid    (slot_valid[i]),
      .ready    (fu_ready[i])
    );
  end

  // Grant scan: channels at or above start_idx first, then the wrapped ones;
  // port k receives the k-th grant.
  always_comb begin
    int cnt;
    cnt        = 0;
    grant      = '0;
    port_valid = '0;
    for (int k = 0; k < NUM_WB; k++) port_sel[k] = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (eligible[i] && ((p == 0) == (i >= int'(start_idx))) && (cnt < NUM_WB)) begin
          grant[i] = 1'b1;
          for (int k = 0; k < NUM_WB; k++) begin
            if (cnt == k) begin
              port_valid[k] = 1'b1;
              port_sel[k]   = IDX_W'(i);
            end
          end
          cnt = cnt + 1;
        end
      end
    end
  end

`ifdef WB_RR_ARB_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_next;

  // The pointer steps just past the last channel granted this cycle.
  always_comb begin
    rr_next = rr_ptr;
    for (int k = 0; k < NUM_WB; k++) begin
      if (port_valid[k]) begin
        rr_next = (port_sel[k] == IDX_W'(NUM_FU - 1)) ? '0 : port_sel[k] + 1'b1;
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr <= '0;
    else     rr_ptr <= rr_next;
  end

  assign start_idx = rr_ptr;
`else
  assign start_idx = '0;
`endif

  // Forwarding mux; ungranted ports present all zeros.
  always_comb begin
    logic [EW-1:0] sel_e;
    sel_e       = '0;
    fwd_valid   = port_valid;
    fwd_data    = '0;
    fwd_rob_idx = '0;
    fwd_rd      = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (port_valid[k]) begin
        sel_e                         = cand_entry[port_sel[k]];
        fwd_data[k*XLEN +: XLEN]      = sel_e[EW-1 -: XLEN];
        fwd_rob_idx[k*ROB_W +: ROB_W] = sel_e[RD_W +: ROB_W];
        fwd_rd[k*RD_W +: RD_W]        = sel_e[RD_W-1:0];
      end
    end
  end

  // Writeback register: forwarding ports delayed by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid   <= '0;
      wb_data    <= '0;
      wb_rob_idx <= '0;
      wb_rd      <= '0;
    end else begin
      wb_valid   <= fwd_valid;
      wb_data    <= fwd_data;
      wb_rob_idx <= fwd_rob_idx;
      wb_rd      <= fwd_rd;
    end
  end

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// Testbench for exe_wb_arbiter: a NUM_WB=1 instance driven by a vector table
// plus directed sequences, and a NUM_WB=2 instance for dual-port grants.
module tb_exe_wb_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (NUM_WB = 1) ----------------
  logic [7:0]   fu_valid;
  logic [255:0] fu_data;
  logic [23:0]  fu_rob_idx;
  logic [55:0]  fu_rd;
  logic [7:0]   fu_ready;
  logic         flush;
  logic [2:0]   flush_rob_idx;
  logic [2:0]   rob_head;
  logic [0:0]   fwd_valid, wb_valid;
  logic [31:0]  fwd_data, wb_data;
  logic [2:0]   fwd_rob_idx, wb_rob_idx;
  logic [6:0]   fwd_rd, wb_rd;

  exe_wb_arbiter #(.NUM_FU(8), .NUM_WB(1), .XLEN(32), .ROB_W(3), .RD_W(7)) u_dut (
    .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_data(fu_data),
    .fu_rob_idx(fu_rob_idx), .fu_rd(fu_rd), .fu_ready(fu_ready),
    .flush(flush), .flush_rob_idx(flush_rob_idx), .rob_head(rob_head),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data), .fwd_rob_idx(fwd_rob_idx), .fwd_rd(fwd_rd),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rob_idx(wb_rob_idx), .wb_rd(wb_rd)
  );

  // ---------------- DUT (NUM_WB = 2) ----------------
  logic [7:0]   fu_valid2;
  logic [255:0] fu_data2;
  logic [23:0]  fu_rob_idx2;
  logic [55:0]  fu_rd2;
  logic [7:0]   fu_ready2;
  logic [1:0]   fwd_valid2, wb_valid2;
  logic [63:0]  fwd_data2, wb_data2;
  logic [5:0]   fwd_rob_idx2, wb_rob_idx2;
  logic [13:0]  fwd_rd2, wb_rd2;

  exe_wb_arbiter #(.NUM_FU(8), .NUM_WB(2), .XLEN(32), .ROB_W(3), .RD_W(7)) u_dut2 (
    .clk(clk), .rst(rst), .fu_valid(fu_valid2), .fu_data(fu_data2),
    .fu_rob_idx(fu_rob_idx2), .fu_rd(fu_rd2), .fu_ready(fu_ready2),
    .flush(1'b0), .flush_rob_idx(3'd0), .rob_head(3'd0),
    .fwd_valid(fwd_valid2), .fwd_data(fwd_data2), .fwd_rob_idx(fwd_rob_idx2), .fwd_rd(fwd_rd2),
    .wb_valid(wb_valid2), .wb_data(wb_data2), .wb_rob_idx(wb_rob_idx2), .wb_rd(wb_rd2)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic        sb_en  = 1'b0;
  logic [41:0] exp_q[$];
  logic        nxt_wb_v = 1'b0;
  logic [41:0] nxt_wb_e = '0;
  logic [41:0] mon_got;
  logic [41:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] ent(input logic [31:0] d, input logic [2:0] r, input int i);
    return {d, r, 7'(i + 8)};
  endfunction

  function automatic logic [23:0] robs8(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
    return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    fu_valid = '0; fu_data = '0; fu_rob_idx = '0; fu_rd = '0;
    fu_valid2 = '0; fu_data2 = '0; fu_rob_idx2 = '0; fu_rd2 = '0;
    flush = 1'b0; flush_rob_idx = '0; rob_head = '0;
  endtask

  task automatic set_ch(input int i, input logic [31:0] d, input logic [2:0] r);
    fu_valid[i]           = 1'b1;
    fu_data[i*32 +: 32]   = d;
    fu_rob_idx[i*3 +: 3]  = r;
    fu_rd[i*7 +: 7]       = 7'(i + 8);
  endtask

  task automatic set_ch2(input int i, input logic [31:0] d, input logic [2:0] r);
    fu_valid2[i]           = 1'b1;
    fu_data2[i*32 +: 32]   = d;
    fu_rob_idx2[i*3 +: 3]  = r;
    fu_rd2[i*7 +: 7]       = 7'(i + 8);
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    nxt_wb_v = 1'b0;
    nxt_wb_e = '0;
    sb_en = 1'b1;
  endtask

  // Wait for every expected result to appear, then confirm all slots are empty.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d_pending required=0", name, exp_q.size());
      exp_q.delete();
    end
    check({name, "_ready"}, 64'(fu_ready), 64'hFF);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor (NUM_WB = 1 instance) ----------------
  always @(negedge clk) begin
    if (sb_en) begin
      if (fu_valid != 8'h00) check("protocol", 64'(fu_valid & ~fu_ready), 64'h0);
      check("wb", 64'({wb_valid, wb_data, wb_rob_idx, wb_rd}), 64'({nxt_wb_v, nxt_wb_e}));
      mon_got = {fwd_data, fwd_rob_idx, fwd_rd};
      if (fwd_valid[0]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fwd_unexpected actual=%h required=none", mon_got);
          nxt_wb_e = mon_got;
        end else begin
          mon_e = exp_q.pop_front();
          check("fwd", 64'(mon_got), 64'(mon_e));
          nxt_wb_e = mon_e;
        end
        nxt_wb_v = 1'b1;
      end else begin
        check("fwd_idle", 64'(mon_got), 64'h0);
        nxt_wb_v = 1'b0;
        nxt_wb_e = '0;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [7:0]  valid;
    logic [23:0] robs;
    logic [2:0]  head;
    logic        flush;
    logic [2:0]  fidx;
    logic [7:0]  surv;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    // Single-cycle presentations; survivors drain in ascending channel order.
    vecs[0] = '{8'h01, robs8(0,0,0,0,0,0,0,0), 3'd0, 1'b0, 3'd0, 8'h01};
    vecs[1] = '{8'hA5, robs8(0,1,2,3,4,5,6,7), 3'd0, 1'b0, 3'd0, 8'hA5};
    vecs[2] = '{8'hFF, robs8(0,1,2,3,4,5,6,7), 3'd0, 1'b0, 3'd0, 8'hFF};
    // head 7, flush rob0: rob6 age7 killed, rob7 age0 kept (wrap-around).
    vecs[3] = '{8'h28, robs8(0,0,0,6,0,7,0,0), 3'd7, 1'b1, 3'd0, 8'h20};
    // head 0, flush rob3: rob4/rob5 killed, rob3 (itself) and rob2 kept.
    vecs[4] = '{8'h0F, robs8(3,4,2,5,0,0,0,0), 3'd0, 1'b1, 3'd3, 8'h05};
    // head 5, flush rob5: rob5 kept, rob4 (age7) killed.
    vecs[5] = '{8'h81, robs8(5,0,0,0,0,0,0,4), 3'd5, 1'b1, 3'd5, 8'h01};
    // head 2, flush rob2: everything younger killed, nothing granted.
    vecs[6] = '{8'h06, robs8(0,3,7,0,0,0,0,0), 3'd2, 1'b1, 3'd2, 8'h00};
    // head 4, flush rob1 (age5): rob2 (age6) killed, rob4/6/0 kept.
    vecs[7] = '{8'hF0, robs8(0,0,0,0,4,6,2,0), 3'd4, 1'b1, 3'd1, 8'hB0};
  end

  // ---------------- test sequence ----------------
  initial begin
    clear_inputs();
    #3;
    // Reset state, no clock edge yet.
    check("rst_ready", 64'(fu_ready), 64'hFF);
    check("rst_wb_valid", 64'(wb_valid), 64'h0);
    check("rst_wb_data", 64'({wb_data, wb_rob_idx, wb_rd}), 64'h0);
    check("rst_fwd_valid", 64'(fwd_valid), 64'h0);
    check("rst_ready2", 64'(fu_ready2), 64'hFF);
    check("rst_wb_valid2", 64'(wb_valid2), 64'h0);

    // Table-driven vectors.
    for (int v = 0; v < NV; v++) begin
      do_reset();
      @(posedge clk);
      #1;
      rob_head      = vecs[v].head;
      flush         = vecs[v].flush;
      flush_rob_idx = vecs[v].fidx;
      for (int i = 0; i < 8; i++) begin
        if (vecs[v].valid[i]) set_ch(i, 32'(v*256 + i*16 + 1), vecs[v].robs[i*3 +: 3]);
      end
      for (int i = 0; i < 8; i++) begin
        if (vecs[v].surv[i]) exp_q.push_back(ent(32'(v*256 + i*16 + 1), vecs[v].robs[i*3 +: 3], i));
      end
      @(posedge clk);
      #1;
      fu_valid = '0;
      flush    = 1'b0;
      drain("vec");
    end

    // Direct + buffered latency with one port.
    do_reset();
    @(posedge clk);
    #1;
    set_ch(0, 32'h11, 3'd1);
    set_ch(2, 32'h22, 3'd2);
    exp_q.push_back(ent(32'h11, 3'd1, 0));
    exp_q.push_back(ent(32'h22, 3'd2, 2));
    @(negedge clk);
    check("t1_c0_fwd", 64'({fwd_valid, fwd_data}), 64'({1'b1, 32'h11}));
    @(posedge clk);
    #1;
    fu_valid = '0;
    @(negedge clk);
    check("t1_c1_ready2", 64'(fu_ready[2]), 64'h0);
    check("t1_c1_fwd", 64'({fwd_valid, fwd_data}), 64'({1'b1, 32'h22}));
    @(negedge clk);
    check("t1_c2_ready2", 64'(fu_ready[2]), 64'h1);
    check("t1_c2_wb", 64'({wb_valid, wb_data}), 64'({1'b1, 32'h22}));
    drain("t1");

    // Flush of buffered slots: rob1 (age3) dies, rob7 (age1) survives.
    do_reset();
    @(posedge clk);
    #1;
    rob_head = 3'd6;
    set_ch(0, 32'h30, 3'd6);
    set_ch(1, 32'h31, 3'd1);
    set_ch(2, 32'h32, 3'd7);
    exp_q.push_back(ent(32'h30, 3'd6, 0));
    @(posedge clk);
    #1;
    fu_valid      = '0;
    flush         = 1'b1;
    flush_rob_idx = 3'd7;
    exp_q.push_back(ent(32'h32, 3'd7, 2));
    @(negedge clk);
    check("t3_slots_held", 64'(fu_ready[2:1]), 64'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("t3_slots_clear", 64'(fu_ready), 64'hFF);
    drain("t3");

    // Two requesters re-presenting whenever ready: fairness vs starvation.
    do_reset();
    sb_en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (fu_ready[i]) set_ch(i, 32'(c*2 + i + 256), 3'd0);
        else             fu_valid[i] = 1'b0;
      end
      @(negedge clk);
`ifdef WB_RR_ARB_EN
      check("t4_rr_grant", 64'({fwd_valid, fwd_rd}), 64'({1'b1, 7'((c % 2) + 8)}));
`else
      check("t4_fixed_grant", 64'({fwd_valid, fwd_rd}), 64'({1'b1, 7'd8}));
`endif
    end
`ifndef WB_RR_ARB_EN
    check("t4_ch1_starved", 64'(fu_ready[1]), 64'h0);
`endif

    // Asynchronous reset mid-cycle with slots full and wb_valid high.
    do_reset();
    sb_en = 1'b0;
    @(posedge clk);
    #1;
    set_ch(0, 32'h50, 3'd0);
    set_ch(1, 32'h51, 3'd1);
    set_ch(2, 32'h52, 3'd2);
    @(posedge clk);
    #1;
    fu_valid = '0;
    #1;
    check("t5_pre_wb_valid", 64'(wb_valid), 64'h1);
    check("t5_pre_slots", 64'(fu_ready[2:1]), 64'h0);
    #1;
    rst = 1'b1;
    #1;
    check("t5_wb_valid", 64'(wb_valid), 64'h0);
    check("t5_wb_data", 64'({wb_data, wb_rob_idx, wb_rd}), 64'h0);
    check("t5_ready", 64'(fu_ready), 64'hFF);
    check("t5_fwd_valid", 64'(fwd_valid), 64'h0);
    do_reset();

    // Two-port instance: ch1/ch3 same cycle, ch6 the next.
    sb_en = 1'b0;
    @(posedge clk);
    #1;
    set_ch2(1, 32'hA1, 3'd1);
    set_ch2(3, 32'hA3, 3'd3);
    set_ch2(6, 32'hA6, 3'd6);
    @(negedge clk);
    check("t2_c0_valid", 64'(fwd_valid2), 64'h3);
    check("t2_c0_rd", 64'(fwd_rd2), 64'({7'd11, 7'd9}));
    check("t2_c0_data", fwd_data2, {32'hA3, 32'hA1});
    @(posedge clk);
    #1;
    fu_valid2 = '0;
    @(negedge clk);
    check("t2_c1_valid", 64'(fwd_valid2), 64'h1);
    check("t2_c1_data", fwd_data2, {32'h0, 32'hA6});
    check("t2_c1_tags", 64'({fwd_rob_idx2, fwd_rd2}), 64'({3'd0, 3'd6, 7'd0, 7'd14}));
    check("t2_c1_wb", 64'({wb_valid2, wb_data2}), {2'b11, 32'hA3, 32'hA1});
    @(negedge clk);
    check("t2_c2_wb", 64'({wb_valid2, wb_rd2}), 64'({2'b01, 7'd0, 7'd14}));
    check("t2_c2_ready", 64'(fu_ready2), 64'hFF);
    @(negedge clk);
    check("t2_c3_idle", 64'({wb_valid2, wb_rd2}), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
